// File: rtl/fifo_word_packer.sv
// Drains bytes from an 8-bit synchronous FIFO and packs them little-endian into
// 32-bit words on a valid/ready stream; flush forces out a partial, keep-masked word.
module fifo_word_packer #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fifo_empty,
  output logic                               fifo_rd,
  input  logic [DATA_W-1:0]                  fifo_data,
  input  logic                               flush,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_W*BYTES_PER_WORD-1:0]   m_data,
  output logic [BYTES_PER_WORD-1:0]          m_keep,
  output logic                               m_last
);

  localparam int WORD_W = DATA_W * BYTES_PER_WORD;

  logic [2:0]                r_count;
  logic                      r_inflight;
  logic                      r_flush_pend;
  logic [WORD_W-1:0]         r_acc;
  logic                      r_valid;
  logic [WORD_W-1:0]         r_data;
  logic [BYTES_PER_WORD-1:0] r_keep;
  logic                      r_last;

  logic                      w_out_free;
  logic                      w_full;
  logic                      w_flush_go;
  logic                      w_emit;
  logic [2:0]                w_count_eff;
  logic [3:0]                w_fill;
  logic                      w_flush_done;
  logic [BYTES_PER_WORD-1:0] w_keep;
  logic [WORD_W-1:0]         w_acc_next;

  // The output register can take a new word when empty or being drained this cycle.
  assign w_out_free = !r_valid || m_ready;
  assign w_full     = (r_count == 3'(BYTES_PER_WORD));
  assign w_flush_go = r_flush_pend && !r_inflight && (r_count != 3'd0);
  assign w_emit     = w_out_free && (w_full || w_flush_go);

  assign w_count_eff  = w_emit ? 3'd0 : r_count;
  assign w_fill       = {1'b0, w_count_eff} + {3'b000, r_inflight};
  assign w_flush_done = r_flush_pend && !r_inflight && ((r_count == 3'd0) || w_emit);

  // Reads stop once the bytes held plus the one in flight fill a word.
  assign fifo_rd = rst_n && !fifo_empty && !r_flush_pend && (w_fill < 4'(BYTES_PER_WORD));

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_slot
      assign w_keep[gi] = (r_count > 3'(gi));
      assign w_acc_next[DATA_W*gi +: DATA_W] =
        (r_inflight && (w_count_eff == 3'(gi))) ? fifo_data :
        w_emit ? {DATA_W{1'b0}} : r_acc[DATA_W*gi +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= 3'd0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_keep       <= '0;
      r_last       <= 1'b0;
    end else begin
      r_inflight <= fifo_rd;
      r_count    <= w_fill[2:0];
      r_acc      <= w_acc_next;
      if (w_flush_done)
        r_flush_pend <= 1'b0;
      else if (flush)
        r_flush_pend <= 1'b1;
      if (w_emit) begin
        r_valid <= 1'b1;
        r_data  <= r_acc;
        r_keep  <= w_keep;
        r_last  <= r_flush_pend;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_last  = r_last;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a queue-based FIFO model feeds bytes,
// expected beats are queued by the stimulus and checked by a negedge monitor.
module tb_fifo_word_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  fq[$];
  beat_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          e0      = -1;
  int          mv      = -1;

  fifo_word_packer #(.DATA_W(8), .BYTES_PER_WORD(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: read data appears one clock after the sampling edge.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() != 0) fifo_data <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, {31'd0, m_valid}, 32'd0);
    chk({name, "_data"},  m_data, 32'd0);
    chk({name, "_keep"},  {28'd0, m_keep}, 32'd0);
    chk({name, "_last"},  {31'd0, m_last}, 32'd0);
    chk({name, "_rd"},    {31'd0, fifo_rd}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; m_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (fifo_rd) begin
            n_tests++;
            if (fifo_empty) begin
              n_fail++;
              $display("FAIL underflow: fifo_rd=1 while fifo_empty=1 at cycle %0d", cyc);
            end
            if (e0 < 0) e0 = cyc;
          end
          if (m_valid && mv < 0) mv = cyc;
          if (m_valid && m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_beat: got data=%h keep=%b last=%b, expected none",
                       m_data, m_keep, m_last);
            end else begin
              beat_t e;
              e = exp_q.pop_front();
              if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
                n_fail++;
                $display("FAIL beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                         m_data, m_keep, m_last, e.d, e.k, e.l);
              end else begin
                $display("[TB] beat data=%h keep=%b last=%b", m_data, m_keep, m_last);
              end
            end
          end
        end
      end
      begin
        // Reset state, including with bytes waiting in the FIFO
        repeat (3) tick();
        chk_reset_outputs("reset");
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        tick();
        chk_reset_outputs("reset_fifo_full");
        // Continuous stream
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h08070605, 4'hF, 1'b0);
        rst_n = 1'b1;
        drain("stream_drain");
        chk("first_valid_latency", 32'(mv - (e0 + 1)), 32'd5);

        // Back-pressure
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
          repeat (5) tick();
          chk("stall_valid", {31'd0, m_valid}, 32'd1);
          chk("stall_data", m_data, 32'hA3A2A1A0);
        end
        for (int i = 0; i < 8; i++) write_byte(8'hB0 + 8'(i));
        repeat (10) tick();
        chk("stall_rd_low", {31'd0, fifo_rd}, 32'd0);
        chk("stall_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
        chk("stall_data_held", m_data, 32'hA3A2A1A0);
        expect_beat(32'hA3A2A1A0, 4'hF, 1'b0);
        expect_beat(32'hB3B2B1B0, 4'hF, 1'b0);
        expect_beat(32'hB7B6B5B4, 4'hF, 1'b0);
        drain("stall_drain");

        // Partial-word flush
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        repeat (6) tick();
        expect_beat(32'h00332211, 4'b0111, 1'b1);
        flush = 1'b1; tick(); flush = 1'b0;
        drain("flush3_drain");

        // Flush with nothing held produces no beat
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (10) tick();
        chk("empty_flush_no_valid", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 4; i++) write_byte(8'hD0 + 8'(i));
        expect_beat(32'hD3D2D1D0, 4'hF, 1'b0);
        drain("after_empty_flush_drain");

        // Flush in the same cycle as a read, one byte already held
        write_byte(8'h55);
        repeat (4) tick();
        write_byte(8'h66);
        flush = 1'b1;
        chk("flush_with_rd", {31'd0, fifo_rd}, 32'd1);
        expect_beat(32'h00006655, 4'b0011, 1'b1);
        tick();
        flush = 1'b0;
        drain("flush_rd_drain");

        // Reset mid-word: two bytes held, one in flight
        write_byte(8'h71); write_byte(8'h72); write_byte(8'h73);
        tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midword_reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) write_byte(8'h80 + 8'(i));
        expect_beat(32'h84838281, 4'hF, 1'b0);
        drain("post_reset_drain");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
